// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader and the fetch memory.
package imem_loader_pkg;

   // Instruction memory size in words, shared with the fetch-side memory.
   localparam int unsigned IMEM_DEPTH = 33001;

   typedef enum logic [2:0] {
      StLen,
      StData,
      StCsum,
      StDone,
      StErr
   } loader_state_e;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and imem write/status bus of the boot loader.
interface imem_loader_if #(
   parameter int unsigned ADDR_W = 16
);
   logic [7:0]        rx_data;
   logic              rx_valid;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic              cpu_hold;
   logic              load_done;
   logic              load_err;

   // Byte source / memory + status observer side.
   modport master (
      output rx_data, rx_valid,
      input  mem_we, mem_addr, mem_wdata, cpu_hold, load_done, load_err
   );

   // Loader side.
   modport slave (
      input  rx_data, rx_valid,
      output mem_we, mem_addr, mem_wdata, cpu_hold, load_done, load_err
   );
endinterface

// File: rtl/imem_loader_word_asm.sv
// Little-endian byte-to-word assembler. The final byte is passed through
// combinationally so the full word is available in the cycle it arrives.
module loader_word_asm (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clear_i,
   input  logic        valid_i,
   input  logic [7:0]  byte_i,
   output logic [31:0] word_o,
   output logic        word_ready_o
);

   logic [1:0]  byte_cnt_q, byte_cnt_d;
   logic [23:0] shift_q, shift_d;

   // Next-state: place each byte at byte_cnt*8, wrap the counter 3->0.
   always_comb begin
      byte_cnt_d = byte_cnt_q;
      shift_d    = shift_q;
      if (clear_i) begin
         byte_cnt_d = 2'd0;
         shift_d    = 24'd0;
      end else if (valid_i) begin
         byte_cnt_d = byte_cnt_q + 2'd1;
         case (byte_cnt_q)
            2'd0:    shift_d[7:0]   = byte_i;
            2'd1:    shift_d[15:8]  = byte_i;
            2'd2:    shift_d[23:16] = byte_i;
            default: ;
         endcase
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         byte_cnt_q <= 2'd0;
         shift_q    <= 24'd0;
      end else begin
         byte_cnt_q <= byte_cnt_d;
         shift_q    <= shift_d;
      end
   end

   assign word_o       = {byte_i, shift_q};
   assign word_ready_o = valid_i && (byte_cnt_q == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Boot loader: frames the UART byte stream as length + words + XOR checksum,
// writes the words into instruction memory and holds the CPU until done.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int unsigned DEPTH     = IMEM_DEPTH,
   parameter int unsigned ADDR_W    = 16,
   parameter int unsigned BASE_ADDR = 0,
   parameter int unsigned TIMEOUT   = 1000000
) (
   input logic         clk,
   input logic         rst_n,
   imem_loader_if.slave bus
);

   // Full 32-bit bound so huge headers are never truncated before the compare.
   localparam logic [31:0] MaxWords = 32'(DEPTH - BASE_ADDR);

   loader_state_e     state_q, state_d;
   logic [31:0]       n_q, n_d;
   logic [31:0]       word_idx_q, word_idx_d;
   logic [7:0]        csum_q, csum_d;
   logic [31:0]       idle_q, idle_d;
   logic              active_q, active_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [31:0]       mem_wdata_q, mem_wdata_d;

   logic        in_frame;
   logic        accept;
   logic        timeout;
   logic [31:0] asm_word;
   logic        asm_ready;

   assign in_frame = (state_q == StLen) || (state_q == StData) || (state_q == StCsum);
   assign accept   = bus.rx_valid && in_frame;
   // A byte in the timeout cycle wins, hence the !accept term.
   assign timeout  = in_frame && active_q && !accept && (idle_q == 32'(TIMEOUT - 1));

   loader_word_asm u_word_asm (
      .clk          (clk),
      .rst_n        (rst_n),
      .clear_i      (timeout),
      .valid_i      (accept),
      .byte_i       (bus.rx_data),
      .word_o       (asm_word),
      .word_ready_o (asm_ready)
   );

   // Next-state: frame FSM, checksum, idle timeout and registered write port.
   always_comb begin
      state_d     = state_q;
      n_d         = n_q;
      word_idx_d  = word_idx_q;
      csum_d      = csum_q;
      idle_d      = idle_q;
      active_d    = active_q;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;

      if (accept) begin
         active_d = 1'b1;
         idle_d   = 32'd0;
      end else if (active_q && in_frame) begin
         idle_d = idle_q + 32'd1;
      end

      if (timeout) begin
         state_d    = StLen;
         word_idx_d = 32'd0;
         csum_d     = 8'd0;
         active_d   = 1'b0;
         idle_d     = 32'd0;
      end else if (accept) begin
         case (state_q)
            StLen: begin
               if (asm_ready) begin
                  n_d        = asm_word;
                  word_idx_d = 32'd0;
                  if (asm_word > MaxWords)  state_d = StErr;
                  else if (asm_word == '0)  state_d = StCsum;
                  else                      state_d = StData;
               end
            end
            StData: begin
               csum_d = csum_q ^ bus.rx_data;
               if (asm_ready) begin
                  mem_we_d    = 1'b1;
                  mem_addr_d  = ADDR_W'(BASE_ADDR + word_idx_q);
                  mem_wdata_d = asm_word;
                  word_idx_d  = word_idx_q + 32'd1;
                  if (word_idx_q == n_q - 32'd1) state_d = StCsum;
               end
            end
            StCsum: begin
               state_d = (bus.rx_data == csum_q) ? StDone : StErr;
            end
            default: ;
         endcase
      end
   end

   // State register; async reset also cancels any in-flight write pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StLen;
         n_q         <= 32'd0;
         word_idx_q  <= 32'd0;
         csum_q      <= 8'd0;
         idle_q      <= 32'd0;
         active_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= 32'd0;
      end else begin
         state_q     <= state_d;
         n_q         <= n_d;
         word_idx_q  <= word_idx_d;
         csum_q      <= csum_d;
         idle_q      <= idle_d;
         active_q    <= active_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.cpu_hold  = (state_q != StDone);
   assign bus.load_done = (state_q == StDone);
   assign bus.load_err  = (state_q == StErr);

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: good/bad images, oversize header, empty
// image, partial-frame timeout, back-to-back bytes and mid-frame reset.
module tb_imem_loader;

   localparam int unsigned ADDR_W = 16;
   localparam int unsigned DEPTH  = 33001;
   localparam int unsigned TMO    = 40;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

   imem_loader #(
      .DEPTH     (DEPTH),
      .ADDR_W    (ADDR_W),
      .BASE_ADDR (0),
      .TIMEOUT   (TMO)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   logic [ADDR_W-1:0] wr_addr_q[$];
   logic [31:0]       wr_data_q[$];

   // Record every write pulse, sampled away from the active edge.
   always @(negedge clk) begin
      if (rst_n && bus.mem_we) begin
         wr_addr_q.push_back(bus.mem_addr);
         wr_data_q.push_back(bus.mem_wdata);
      end
   end

   task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Callers are at posedge+1; b2b keeps rx_valid high across bytes.
   task automatic send_byte(input logic [7:0] b, input bit b2b);
      if (!b2b) begin
         bus.rx_valid = 1'b0;
         @(posedge clk); #1;
      end
      bus.rx_data  = b;
      bus.rx_valid = 1'b1;
      @(posedge clk); #1;
      bus.rx_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w, input bit b2b);
      send_byte(w[7:0], b2b);
      send_byte(w[15:8], b2b);
      send_byte(w[23:16], b2b);
      send_byte(w[31:24], b2b);
   endtask

   // Two-word image; XOR of 13 00 00 00 EF BE AD DE is 0x31.
   task automatic send_img(input logic [7:0] csum, input bit b2b);
      send_word(32'd2, b2b);
      send_word(32'h0000_0013, b2b);
      send_word(32'hDEAD_BEEF, b2b);
      send_byte(csum, b2b);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      bus.rx_valid = 1'b0;
      #12;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      wr_addr_q.delete();
      wr_data_q.delete();
   endtask

   task automatic chk_img_writes(input string tag);
      chk_eq({tag, "_nwr"}, 64'(wr_addr_q.size()), 64'd2);
      if (wr_addr_q.size() == 2) begin
         chk_eq({tag, "_a0"}, 64'(wr_addr_q[0]), 64'd0);
         chk_eq({tag, "_d0"}, 64'(wr_data_q[0]), 64'h13);
         chk_eq({tag, "_a1"}, 64'(wr_addr_q[1]), 64'd1);
         chk_eq({tag, "_d1"}, 64'(wr_data_q[1]), 64'hDEAD_BEEF);
      end
   endtask

   task automatic chk_status(input string tag, input logic done, input logic err,
                             input logic hold);
      chk_eq({tag, "_done"}, 64'(bus.load_done), 64'(done));
      chk_eq({tag, "_err"},  64'(bus.load_err),  64'(err));
      chk_eq({tag, "_hold"}, 64'(bus.cpu_hold),  64'(hold));
   endtask

   initial begin
      bus.rx_data  = 8'd0;
      bus.rx_valid = 1'b0;
      #2;
      // Reset values while rst_n is low.
      chk_eq("rst_we",    64'(bus.mem_we),    64'd0);
      chk_eq("rst_addr",  64'(bus.mem_addr),  64'd0);
      chk_eq("rst_wdata", 64'(bus.mem_wdata), 64'd0);
      chk_status("rst", 1'b0, 1'b0, 1'b1);
      do_reset();

      // 1: good image, then a stray byte in DONE is ignored.
      send_img(8'h31, 1'b0);
      chk_status("s1", 1'b1, 1'b0, 1'b0);
      repeat (3) @(posedge clk); #1;
      send_word(32'h1234_5678, 1'b0);
      repeat (2) @(posedge clk); #1;
      chk_img_writes("s1");
      chk_status("s1_after", 1'b1, 1'b0, 1'b0);

      // 2: bad checksum, writes still happen; stray bytes in ERR ignored.
      do_reset();
      send_img(8'h00, 1'b0);
      chk_status("s2", 1'b0, 1'b1, 1'b1);
      send_img(8'h31, 1'b0);
      repeat (2) @(posedge clk); #1;
      chk_img_writes("s2");
      chk_status("s2_after", 1'b0, 1'b1, 1'b1);

      // 2b: checksum 0x9F is not the XOR of this payload.
      do_reset();
      send_img(8'h9F, 1'b0);
      chk_status("s2b", 1'b0, 1'b1, 1'b1);

      // 3: N = DEPTH+1 errors right after the 4th header byte, no writes.
      do_reset();
      send_word(32'(DEPTH + 1), 1'b0);
      chk_status("s3", 1'b0, 1'b1, 1'b1);
      send_word(32'h0000_0013, 1'b0);
      repeat (2) @(posedge clk); #1;
      chk_eq("s3_nwr", 64'(wr_addr_q.size()), 64'd0);

      // 3b: full 32-bit header 0xFFFFFFFF.
      do_reset();
      send_word(32'hFFFF_FFFF, 1'b1);
      chk_status("s3b", 1'b0, 1'b1, 1'b1);

      // 3c: N = DEPTH exactly is accepted.
      do_reset();
      send_word(32'(DEPTH), 1'b0);
      chk_status("s3c", 1'b0, 1'b0, 1'b1);

      // 4: empty image.
      do_reset();
      send_word(32'd0, 1'b0);
      send_byte(8'h00, 1'b0);
      repeat (2) @(posedge clk); #1;
      chk_status("s4", 1'b1, 1'b0, 1'b0);
      chk_eq("s4_nwr", 64'(wr_addr_q.size()), 64'd0);

      // 5: partial header dropped after TIMEOUT idle cycles.
      do_reset();
      send_byte(8'hAA, 1'b0);
      send_byte(8'h55, 1'b0);
      repeat (TMO + 2) @(posedge clk); #1;
      send_img(8'h31, 1'b0);
      repeat (2) @(posedge clk); #1;
      chk_status("s5", 1'b1, 1'b0, 1'b0);
      chk_img_writes("s5");

      // 6: back-to-back frame.
      do_reset();
      send_img(8'h31, 1'b1);
      repeat (2) @(posedge clk); #1;
      chk_status("s6", 1'b1, 1'b0, 1'b0);
      chk_img_writes("s6");

      // 6b: async reset while a write pulse is in flight.
      do_reset();
      send_word(32'd2, 1'b1);
      send_word(32'hCAFE_F00D, 1'b1);
      chk_eq("s6b_we_pre", 64'(bus.mem_we), 64'd1);
      #1;
      rst_n = 1'b0;
      #1;
      chk_eq("s6b_we",    64'(bus.mem_we),    64'd0);
      chk_eq("s6b_addr",  64'(bus.mem_addr),  64'd0);
      chk_eq("s6b_wdata", 64'(bus.mem_wdata), 64'd0);
      chk_status("s6b", 1'b0, 1'b0, 1'b1);
      do_reset();
      send_img(8'h31, 1'b1);
      repeat (2) @(posedge clk); #1;
      chk_status("s6b_reload", 1'b1, 1'b0, 1'b0);
      chk_img_writes("s6b_reload");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Hard stop in case the bench itself stalls.
   initial begin
      #2_000_000;
      $display("FAIL watchdog got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
